// File: rtl/amba_pkt_reg_if.sv
// amba_pkt_reg_if: router FSM strobes, source byte stream and
// RAM write-side results for the packet register stage.
interface amba_pkt_reg_if #(
  parameter int DATA_WIDTH = 8
);

  logic                  pkt_valid;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  ram_full;
  logic                  detect_add;
  logic                  lfd_state;
  logic                  ld_state;
  logic                  laf_state;
  logic                  full_state;
  logic                  rst_int_cam;
  logic [DATA_WIDTH-1:0] dout;
  logic                  parity_done;
  logic                  low_packet_valid;
  logic                  err;
  logic                  len_err;

  modport master (
    output pkt_valid,
    output data_in,
    output ram_full,
    output detect_add,
    output lfd_state,
    output ld_state,
    output laf_state,
    output full_state,
    output rst_int_cam,
    input  dout,
    input  parity_done,
    input  low_packet_valid,
    input  err,
    input  len_err
  );

  modport slave (
    input  pkt_valid,
    input  data_in,
    input  ram_full,
    input  detect_add,
    input  lfd_state,
    input  ld_state,
    input  laf_state,
    input  full_state,
    input  rst_int_cam,
    output dout,
    output parity_done,
    output low_packet_valid,
    output err,
    output len_err
  );

endinterface

// File: rtl/amba_pkt_reg.sv
// amba_pkt_reg: header latch, dout steering, full-hold and parity check.
// Optional payload length check enabled by AMBA_PKT_LEN_CHECK_EN.
module amba_pkt_reg #(
  parameter int DATA_WIDTH = 8,
  parameter int LEN_MSB    = 7
) (
  input logic              clock,
  input logic              resetn,
  amba_pkt_reg_if.slave    bus
);

  // Reject parameter sets where the length field does not fit the byte
  if (DATA_WIDTH < 8 || LEN_MSB < 2 || LEN_MSB >= DATA_WIDTH) begin : g_bad_cfg
    $error("amba_pkt_reg: illegal DATA_WIDTH/LEN_MSB");
  end

  logic [DATA_WIDTH-1:0] hdr_q, hdr_d;
  logic [DATA_WIDTH-1:0] hold_q, hold_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic [DATA_WIDTH-1:0] int_par_q, int_par_d;
  logic [DATA_WIDTH-1:0] pkt_par_q, pkt_par_d;
  logic                  lpv_q, lpv_d;
  logic                  done_q, done_d;
  logic                  done_dly_q, done_dly_d;
  logic                  err_q, err_d;
  logic                  done_rise;
  logic                  ld_take;

  assign done_rise = done_q & ~done_dly_q;
  assign ld_take   = bus.ld_state & bus.pkt_valid & ~bus.full_state;

  // Header latch: only a valid byte with a routable address
  always_comb begin
    hdr_d = hdr_q;
    if (bus.detect_add && bus.pkt_valid &&
        bus.data_in[1:0] != 2'b11) begin
      hdr_d = bus.data_in;
    end
  end

  // dout steering and one-byte hold while the RAM is full
  always_comb begin
    dout_d = dout_q;
    hold_d = hold_q;
    if (bus.lfd_state) begin
      dout_d = hdr_q;
    end else if (bus.ld_state) begin
      if (bus.ram_full) begin
        hold_d = bus.data_in;
      end else begin
        dout_d = bus.data_in;
      end
    end else if (bus.laf_state) begin
      dout_d = hold_q;
    end
  end

  // Running parity; the held byte was folded in when first sampled
  always_comb begin
    int_par_d = int_par_q;
    if (bus.detect_add) begin
      int_par_d = '0;
    end else if (bus.lfd_state) begin
      int_par_d = int_par_q ^ hdr_q;
    end else if (ld_take) begin
      int_par_d = int_par_q ^ bus.data_in;
    end
  end

  // Received parity byte arrives with pkt_valid low
  always_comb begin
    pkt_par_d = pkt_par_q;
    if (bus.ld_state && !bus.pkt_valid) begin
      pkt_par_d = bus.data_in;
    end
  end

  // low_packet_valid: set wins over clear
  always_comb begin
    lpv_d = lpv_q;
    if (bus.ld_state && !bus.pkt_valid && bus.ram_full) begin
      lpv_d = 1'b1;
    end else if (bus.rst_int_cam || bus.detect_add) begin
      lpv_d = 1'b0;
    end
  end

  // parity_done: direct capture, or deferred through LOAD_AFTER_FULL
  always_comb begin
    done_d     = done_q;
    done_dly_d = done_q;
    if ((bus.ld_state && !bus.pkt_valid && !bus.ram_full) ||
        (bus.laf_state && lpv_q && !done_q)) begin
      done_d = 1'b1;
    end else if (bus.detect_add) begin
      done_d = 1'b0;
    end
  end

  // Parity error evaluated once, one cycle after parity_done rises
  always_comb begin
    err_d = err_q;
    if (bus.detect_add) begin
      err_d = 1'b0;
    end else if (done_rise) begin
      err_d = (int_par_q != pkt_par_q);
    end
  end

  // State registers
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      hdr_q      <= '0;
      hold_q     <= '0;
      dout_q     <= '0;
      int_par_q  <= '0;
      pkt_par_q  <= '0;
      lpv_q      <= 1'b0;
      done_q     <= 1'b0;
      done_dly_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      hdr_q      <= hdr_d;
      hold_q     <= hold_d;
      dout_q     <= dout_d;
      int_par_q  <= int_par_d;
      pkt_par_q  <= pkt_par_d;
      lpv_q      <= lpv_d;
      done_q     <= done_d;
      done_dly_q <= done_dly_d;
      err_q      <= err_d;
    end
  end

  assign bus.dout             = dout_q;
  assign bus.parity_done      = done_q;
  assign bus.low_packet_valid = lpv_q;
  assign bus.err              = err_q;

`ifdef AMBA_PKT_LEN_CHECK_EN
  logic [5:0] cnt_q, cnt_d;
  logic       len_err_q, len_err_d;
  logic [5:0] len_fld;

  assign len_fld = 6'(hdr_q[LEN_MSB:2]);

  // Payload counter and length compare at parity_done rise
  always_comb begin
    cnt_d     = cnt_q;
    len_err_d = len_err_q;
    if (bus.detect_add) begin
      cnt_d     = '0;
      len_err_d = 1'b0;
    end else begin
      if (ld_take) begin
        cnt_d = cnt_q + 6'd1;
      end
      if (done_rise) begin
        len_err_d = (cnt_q != len_fld);
      end
    end
  end

  // Length-check registers
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      cnt_q     <= '0;
      len_err_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      len_err_q <= len_err_d;
    end
  end

  assign bus.len_err = len_err_q;
`else
  assign bus.len_err = 1'b0;
`endif

endmodule

// File: tb/tb_amba_pkt_reg.sv
// tb_amba_pkt_reg: directed packets with hand-computed expectations.
// Length expectations follow AMBA_PKT_LEN_CHECK_EN.
module tb_amba_pkt_reg;

`ifdef AMBA_PKT_LEN_CHECK_EN
  localparam logic LEN_ON = 1'b1;
`else
  localparam logic LEN_ON = 1'b0;
`endif

  logic clock;
  logic resetn;
  int   nvec;
  int   nfail;

  amba_pkt_reg_if #(.DATA_WIDTH(8)) bus ();

  amba_pkt_reg #(
    .DATA_WIDTH(8),
    .LEN_MSB(7)
  ) dut (
    .clock(clock),
    .resetn(resetn),
    .bus(bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.pkt_valid   = 1'b0;
    bus.data_in     = 8'h00;
    bus.ram_full    = 1'b0;
    bus.detect_add  = 1'b0;
    bus.lfd_state   = 1'b0;
    bus.ld_state    = 1'b0;
    bus.laf_state   = 1'b0;
    bus.full_state  = 1'b0;
    bus.rst_int_cam = 1'b0;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic run_pkt(input logic [7:0] h, input int n,
                         input logic [7:0] par, input logic exp_err,
                         input logic exp_len);
    idle(); bus.detect_add = 1'b1; bus.pkt_valid = 1'b1;
    bus.data_in = h; tick();
    chk("da_done", {7'd0, bus.parity_done}, 8'd0);
    chk("da_err", {7'd0, bus.err}, 8'd0);
    idle(); bus.lfd_state = 1'b1; bus.pkt_valid = 1'b1;
    bus.data_in = 8'h01; tick();
    chk("lfd_dout", bus.dout, h);
    for (int i = 1; i <= n; i++) begin
      idle(); bus.ld_state = 1'b1; bus.pkt_valid = 1'b1;
      bus.data_in = 8'(i); tick();
      chk("ld_dout", bus.dout, 8'(i));
    end
    idle(); bus.ld_state = 1'b1; bus.data_in = par; tick();
    chk("par_dout", bus.dout, par);
    chk("par_done", {7'd0, bus.parity_done}, 8'd1);
    idle(); bus.rst_int_cam = 1'b1; tick();
    chk("err", {7'd0, bus.err}, {7'd0, exp_err});
    chk("len_err", {7'd0, bus.len_err}, {7'd0, exp_len});
    idle(); tick();
    chk("err_hold", {7'd0, bus.err}, {7'd0, exp_err});
  endtask

  initial begin
    nvec  = 0;
    nfail = 0;
    idle();
    resetn = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_dout", bus.dout, 8'h00);
    chk("rst_done", {7'd0, bus.parity_done}, 8'd0);
    chk("rst_lpv", {7'd0, bus.low_packet_valid}, 8'd0);
    chk("rst_err", {7'd0, bus.err}, 8'd0);
    chk("rst_len", {7'd0, bus.len_err}, 8'd0);
    resetn = 1'b1;
    tick();

    // good packet, then bad parity; next detect_add clears err
    run_pkt(8'h14, 5, 8'h15, 1'b0, 1'b0);
    run_pkt(8'h14, 5, 8'h16, 1'b1, 1'b0);
    run_pkt(8'h14, 5, 8'h15, 1'b0, 1'b0);

    // ram_full while payload 0x03 is in LOAD_DATA
    idle(); bus.detect_add = 1'b1; bus.pkt_valid = 1'b1;
    bus.data_in = 8'h14; tick();
    idle(); bus.lfd_state = 1'b1; bus.pkt_valid = 1'b1; tick();
    chk("f_hdr", bus.dout, 8'h14);
    for (int i = 1; i <= 3; i++) begin
      idle(); bus.ld_state = 1'b1; bus.pkt_valid = 1'b1;
      bus.data_in = 8'(i); bus.ram_full = (i == 3); tick();
    end
    chk("f_hold", bus.dout, 8'h02);
    idle(); bus.full_state = 1'b1; bus.ram_full = 1'b1;
    bus.pkt_valid = 1'b1; bus.data_in = 8'h04; tick();
    chk("f_full", bus.dout, 8'h02);
    idle(); bus.laf_state = 1'b1; bus.pkt_valid = 1'b1;
    bus.data_in = 8'h04; tick();
    chk("f_laf", bus.dout, 8'h03);
    for (int i = 4; i <= 5; i++) begin
      idle(); bus.ld_state = 1'b1; bus.pkt_valid = 1'b1;
      bus.data_in = 8'(i); tick();
      chk("f_ld", bus.dout, 8'(i));
    end
    idle(); bus.ld_state = 1'b1; bus.data_in = 8'h15; tick();
    chk("f_done", {7'd0, bus.parity_done}, 8'd1);
    idle(); bus.rst_int_cam = 1'b1; tick();
    chk("f_err", {7'd0, bus.err}, 8'd0);

    // parity byte arrives while RAM is full
    idle(); bus.detect_add = 1'b1; bus.pkt_valid = 1'b1;
    bus.data_in = 8'h14; tick();
    idle(); bus.lfd_state = 1'b1; bus.pkt_valid = 1'b1; tick();
    for (int i = 1; i <= 5; i++) begin
      idle(); bus.ld_state = 1'b1; bus.pkt_valid = 1'b1;
      bus.data_in = 8'(i); tick();
    end
    idle(); bus.ld_state = 1'b1; bus.ram_full = 1'b1;
    bus.data_in = 8'h15; tick();
    chk("l_lpv", {7'd0, bus.low_packet_valid}, 8'd1);
    chk("l_done0", {7'd0, bus.parity_done}, 8'd0);
    chk("l_dout", bus.dout, 8'h05);
    idle(); bus.full_state = 1'b1; bus.ram_full = 1'b1; tick();
    chk("l_done1", {7'd0, bus.parity_done}, 8'd0);
    idle(); bus.laf_state = 1'b1; tick();
    chk("l_done2", {7'd0, bus.parity_done}, 8'd1);
    chk("l_laf", bus.dout, 8'h15);
    idle(); bus.rst_int_cam = 1'b1; tick();
    chk("l_lpv_clr", {7'd0, bus.low_packet_valid}, 8'd0);
    chk("l_err", {7'd0, bus.err}, 8'd0);

    // reset mid-payload after 0x02
    idle(); bus.detect_add = 1'b1; bus.pkt_valid = 1'b1;
    bus.data_in = 8'h14; tick();
    idle(); bus.lfd_state = 1'b1; bus.pkt_valid = 1'b1; tick();
    for (int i = 1; i <= 2; i++) begin
      idle(); bus.ld_state = 1'b1; bus.pkt_valid = 1'b1;
      bus.data_in = 8'(i); tick();
    end
    chk("r_pre", bus.dout, 8'h02);
    resetn = 1'b0;
    #1;
    chk("r_dout", bus.dout, 8'h00);
    chk("r_done", {7'd0, bus.parity_done}, 8'd0);
    chk("r_err", {7'd0, bus.err}, 8'd0);
    chk("r_lpv", {7'd0, bus.low_packet_valid}, 8'd0);
    idle(); tick();
    resetn = 1'b1;
    tick();
    run_pkt(8'h14, 5, 8'h15, 1'b0, 1'b0);

    // short packet: 4 payload bytes against a length of 5
    run_pkt(8'h14, 4, 8'h10, 1'b0, LEN_ON);

    // address 11 header must not replace the latched header
    idle(); bus.detect_add = 1'b1; bus.pkt_valid = 1'b1;
    bus.data_in = 8'h17; tick();
    idle(); bus.lfd_state = 1'b1; tick();
    chk("a11_hdr", bus.dout, 8'h14);
    idle(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
